mips_mc_ctrl: RTL and testbench
===============================

Name: mips_mc_ctrl

Overview:
- Multi-cycle main controller for the p5 MIPS datapath (PC, IR, GRF, ALU, EXT, IM, DM), replacing the single-cycle combinational controller.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB and drives every datapath write-enable and mux select.
- Handshakes with instruction and data memories that may insert wait states; a bounded wait timeout traps into an error state.

Parameters:
- WAIT_LIMIT, 15, maximum wait cycles per memory request before trapping to S_ERR; 0 disables the timeout.
- CNT_W, 4, width of the wait counter; must satisfy 2^CNT_W > WAIT_LIMIT.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- opcode  in  6  IR[31:26].
- funct  in  6  IR[5:0].
- alu_zero  in  1  ALU equal flag, used by beq.
- imem_ready  in  1  instruction word valid this cycle.
- dmem_ready  in  1  data access complete this cycle.
- imem_req  out  1  instruction fetch request.
- dmem_req  out  1  data access request.
- dmem_we  out  1  store enable, qualified by dmem_req.
- pc_we  out  1  PC load.
- ir_we  out  1  IR load.
- reg_we  out  1  GRF write.
- npc_sel  out  2  00 PC+4, 01 branch, 10 j/jal target, 11 rs (jr).
- alu_op  out  3  000 add, 001 sub, 010 or, 011 lui.
- alu_src_b  out  1  0 rt, 1 EXT output.
- ext_op  out  1  0 zero-extend, 1 sign-extend.
- reg_dst  out  2  00 rt, 01 rd, 10 $31.
- wd_sel  out  2  00 ALU, 01 DM, 10 PC (already PC+4).
- instr_done  out  1  1-cycle pulse in an instruction's final cycle.
- illegal  out  1  1-cycle pulse in DECODE for an unsupported opcode or funct.
- bus_err  out  1  sticky; high while in S_ERR.
- state  out  3  current state encoding, for debug.

Behaviour:
- States: S_FETCH=0, S_DECODE=1, S_EXEC=2, S_MEM=3, S_WB=4, S_ERR=5. All outputs are combinational from the state register, opcode and funct.
- Reset low: state=S_FETCH, wait counter=0, all outputs 0, including imem_req. Reset asserted mid-instruction aborts it with no write.
- S_FETCH: imem_req=1. When imem_ready=1: ir_we=1, pc_we=1, npc_sel=00, go to S_DECODE. Otherwise stay in S_FETCH and count a wait cycle.
- S_DECODE: no writes. A supported instruction goes to S_EXEC. An unsupported one asserts illegal and instr_done, then goes to S_FETCH (treated as a nop).
- S_EXEC, by instruction:
  - addu/subu: go to S_WB.
  - ori: alu_src_b=1, ext_op=0; go to S_WB.
  - lui: alu_op=011; go to S_WB.
  - lw/sw: add, alu_src_b=1, ext_op=1; go to S_MEM.
  - beq: alu_op=sub; pc_we=alu_zero, npc_sel=01; instr_done; go to S_FETCH.
  - j: pc_we=1, npc_sel=10; instr_done; go to S_FETCH.
  - jal: pc_we=1, npc_sel=10; go to S_WB.
  - jr: pc_we=1, npc_sel=11; instr_done; go to S_FETCH.
- S_MEM: dmem_req=1, dmem_we=(sw). When dmem_ready=1: lw goes to S_WB; sw asserts instr_done and goes to S_FETCH. Otherwise stay and count a wait cycle.
- S_WB: reg_we=1 and instr_done, then S_FETCH.
  - R-type: reg_dst=01, wd_sel=00.
  - ori/lui: reg_dst=00, wd_sel=00.
  - lw: reg_dst=00, wd_sel=01.
  - jal: reg_dst=10, wd_sel=10 (PC already holds PC+4 of jal).
  - alu_op and alu_src_b hold their S_EXEC values during S_WB.
- Cycle counts with zero-wait memory: beq/j/jr 3; R-type/ori/lui/jal/sw 4; lw 5; illegal 2.
- Memory handshake:
  - A ready seen in the same cycle the request is first raised is a zero-wait completion.
  - A ready arriving while the request is low is ignored.
  - The request stays high until ready.
- Wait counter: increments each cycle with req=1 and ready=0, and clears on ready and on any state change.
- Timeout: when the counter reaches WAIT_LIMIT with ready still 0, go to S_ERR on the next edge.
- S_ERR: all requests and write enables 0, bus_err=1; it is left only by reset.
- The WAIT_LIMIT=0 timeout bypass is decided at elaboration time.

Decomposition:
- Shared package mips_ctrl_pkg holds:
  - Opcodes: R=000000, ori=001101, lw=100011, sw=101011, beq=000100, lui=001111, j=000010, jal=000011.
  - Functs: addu=100001, subu=100011, jr=001000.
  - State encodings, npc_sel/alu_op/reg_dst/wd_sel encodings.
- One sub-module, mips_ins_decode: combinational opcode/funct to one-hot instruction class plus an illegal flag. The FSM in mips_mc_ctrl consumes that class.

Test Plan:
- addu with always-ready memories: state sequence 0,1,2,4,0; reg_we=1, reg_dst=01 only in cycle 4; instr_done pulses once.
- lw with dmem_ready delayed 3 cycles: S_MEM held 4 cycles with dmem_req=1 and dmem_we=0; then S_WB with wd_sel=01; total 8 cycles.
- beq with alu_zero=0, then with alu_zero=1: pc_we in S_EXEC is 0 then 1, npc_sel=01; each takes 3 cycles.
- jal: S_EXEC has pc_we=1, npc_sel=10; S_WB has reg_dst=10, wd_sel=10. opcode=111111 gives an illegal pulse and a return to S_FETCH after 2 cycles with no writes.
- imem_ready held 0 with WAIT_LIMIT=15: after 15 wait cycles, state=5 and bus_err=1 stay until reset goes low; then state=0 and all outputs 0.
- Reset pulled low during S_MEM of sw: dmem_req and dmem_we drop immediately (asynchronous), no store; fetch restarts after reset is released.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mips_ctrl_pkg: shared encodings for the multi-cycle MIPS controller. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package mips_ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_ERR    = 3'd5
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_JR    = 6'b001000;

  localparam logic [1:0] NPC_PC4  = 2'b00;
  localparam logic [1:0] NPC_BR   = 2'b01;
  localparam logic [1:0] NPC_JMP  = 2'b10;
  localparam logic [1:0] NPC_RS   = 2'b11;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_OR   = 3'b010;
  localparam logic [2:0] ALU_LUI  = 3'b011;

  localparam logic [1:0] RD_RT    = 2'b00;
  localparam logic [1:0] RD_RD    = 2'b01;
  localparam logic [1:0] RD_RA    = 2'b10;

  localparam logic [1:0] WD_ALU   = 2'b00;
  localparam logic [1:0] WD_DM    = 2'b01;
  localparam logic [1:0] WD_PC    = 2'b10;

  typedef struct packed {
    logic addu;
    logic subu;
    logic jr;
    logic ori;
    logic lui;
    logic lw;
    logic sw;
    logic beq;
    logic j;
    logic jal;
  } ins_class_t;

endpackage

`default_nettype wire

// File: rtl/mips_ins_decode.sv
// ---------------------------------------------------------------------------
// mips_ins_decode: opcode/funct to one-hot instruction class. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mips_ins_decode
  import mips_ctrl_pkg::*;
(
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  output ins_class_t  cls,
  output logic        illegal
);

  always_comb begin
    cls = '0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADDU: cls.addu = 1'b1;
          FN_SUBU: cls.subu = 1'b1;
          FN_JR:   cls.jr   = 1'b1;
          default: ;
        endcase
      end
      OP_ORI:  cls.ori = 1'b1;
      OP_LUI:  cls.lui = 1'b1;
      OP_LW:   cls.lw  = 1'b1;
      OP_SW:   cls.sw  = 1'b1;
      OP_BEQ:  cls.beq = 1'b1;
      OP_J:    cls.j   = 1'b1;
      OP_JAL:  cls.jal = 1'b1;
      default: ;
    endcase
    illegal = (cls == '0);
  end

endmodule

`default_nettype wire

// File: rtl/mips_mc_ctrl.sv
// ---------------------------------------------------------------------------
// mips_mc_ctrl: multi-cycle MIPS main controller with memory wait timeout. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mips_mc_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int WAIT_LIMIT = 15,
  parameter int CNT_W      = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       alu_zero,
  input  logic       imem_ready,
  input  logic       dmem_ready,
  output logic       imem_req,
  output logic       dmem_req,
  output logic       dmem_we,
  output logic       pc_we,
  output logic       ir_we,
  output logic       reg_we,
  output logic [1:0] npc_sel,
  output logic [2:0] alu_op,
  output logic       alu_src_b,
  output logic       ext_op,
  output logic [1:0] reg_dst,
  output logic [1:0] wd_sel,
  output logic       instr_done,
  output logic       illegal,
  output logic       bus_err,
  output logic [2:0] state
);

  state_t             r_state;
  state_t             w_next;
  logic [CNT_W-1:0]   r_wait_cnt;
  logic               w_waiting;
  logic               w_timeout;
  ins_class_t         w_cls;
  logic               w_illegal;

  mips_ins_decode u_decode (
    .opcode  (opcode),
    .funct   (funct),
    .cls     (w_cls),
    .illegal (w_illegal)
  );

  assign state     = r_state;
  assign w_waiting = ((r_state == S_FETCH) && !imem_ready) ||
                     ((r_state == S_MEM)   && !dmem_ready);

  generate
    if (WAIT_LIMIT == 0) begin : g_no_timeout
      assign w_timeout = 1'b0;
    end else begin : g_timeout
      assign w_timeout = w_waiting && (r_wait_cnt == CNT_W'(WAIT_LIMIT));
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_FETCH;
      r_wait_cnt <= '0;
    end else begin
      r_state    <= w_next;
      r_wait_cnt <= (w_waiting && (w_next == r_state)) ? r_wait_cnt + CNT_W'(1) : '0;
    end
  end

  always_comb begin
    w_next     = r_state;
    imem_req   = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    pc_we      = 1'b0;
    ir_we      = 1'b0;
    reg_we     = 1'b0;
    npc_sel    = NPC_PC4;
    alu_op     = ALU_ADD;
    alu_src_b  = 1'b0;
    ext_op     = 1'b0;
    reg_dst    = RD_RT;
    wd_sel     = WD_ALU;
    instr_done = 1'b0;
    illegal    = 1'b0;
    bus_err    = 1'b0;

    // ALU controls stay stable from EXEC through WB so address/result hold.
    if ((r_state == S_EXEC) || (r_state == S_MEM) || (r_state == S_WB)) begin
      if (w_cls.subu || w_cls.beq) begin
        alu_op = ALU_SUB;
      end else if (w_cls.ori) begin
        alu_op    = ALU_OR;
        alu_src_b = 1'b1;
      end else if (w_cls.lui) begin
        alu_op    = ALU_LUI;
        alu_src_b = 1'b1;
      end else if (w_cls.lw || w_cls.sw) begin
        alu_src_b = 1'b1;
        ext_op    = 1'b1;
      end
    end

    case (r_state)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_we  = 1'b1;
          pc_we  = 1'b1;
          w_next = S_DECODE;
        end
      end
      S_DECODE: begin
        if (w_illegal) begin
          illegal    = 1'b1;
          instr_done = 1'b1;
          w_next     = S_FETCH;
        end else begin
          w_next = S_EXEC;
        end
      end
      S_EXEC: begin
        if (w_cls.beq) begin
          pc_we      = alu_zero;
          npc_sel    = NPC_BR;
          instr_done = 1'b1;
          w_next     = S_FETCH;
        end else if (w_cls.j) begin
          pc_we      = 1'b1;
          npc_sel    = NPC_JMP;
          instr_done = 1'b1;
          w_next     = S_FETCH;
        end else if (w_cls.jr) begin
          pc_we      = 1'b1;
          npc_sel    = NPC_RS;
          instr_done = 1'b1;
          w_next     = S_FETCH;
        end else if (w_cls.jal) begin
          pc_we   = 1'b1;
          npc_sel = NPC_JMP;
          w_next  = S_WB;
        end else if (w_cls.lw || w_cls.sw) begin
          w_next = S_MEM;
        end else begin
          w_next = S_WB;
        end
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = w_cls.sw;
        if (dmem_ready) begin
          if (w_cls.sw) begin
            instr_done = 1'b1;
            w_next     = S_FETCH;
          end else begin
            w_next = S_WB;
          end
        end
      end
      S_WB: begin
        reg_we     = 1'b1;
        instr_done = 1'b1;
        w_next     = S_FETCH;
        if (w_cls.addu || w_cls.subu) begin
          reg_dst = RD_RD;
        end else if (w_cls.lw) begin
          wd_sel = WD_DM;
        end else if (w_cls.jal) begin
          reg_dst = RD_RA;
          wd_sel  = WD_PC;
        end
      end
      S_ERR: begin
        bus_err = 1'b1;
      end
      default: begin
        w_next = S_ERR;
      end
    endcase

    if (w_timeout) begin
      w_next = S_ERR;
    end

    // Outputs fall silent the moment reset asserts, aborting any access.
    if (!reset) begin
      imem_req   = 1'b0;
      dmem_req   = 1'b0;
      dmem_we    = 1'b0;
      pc_we      = 1'b0;
      ir_we      = 1'b0;
      reg_we     = 1'b0;
      npc_sel    = NPC_PC4;
      alu_op     = ALU_ADD;
      alu_src_b  = 1'b0;
      ext_op     = 1'b0;
      reg_dst    = RD_RT;
      wd_sel     = WD_ALU;
      instr_done = 1'b0;
      illegal    = 1'b0;
      bus_err    = 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mips_mc_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mips_mc_ctrl: per-cycle scoreboard bench for mips_mc_ctrl. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mips_mc_ctrl;

  typedef struct packed {
    logic [2:0] st;
    logic       ireq;
    logic       dreq;
    logic       dwe;
    logic       pcwe;
    logic       irwe;
    logic       regwe;
    logic [1:0] npc;
    logic [2:0] aop;
    logic       asrc;
    logic       ext;
    logic [1:0] rdst;
    logic [1:0] wsel;
    logic       done;
    logic       ill;
    logic       berr;
  } obs_t;

  typedef struct {
    obs_t o;
    logic ir;
    logic dr;
    logic z;
  } step_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [5:0] opcode = '0;
  logic [5:0] funct = '0;
  logic       alu_zero = 1'b0;
  logic       imem_ready = 1'b0;
  logic       dmem_ready = 1'b0;
  logic       imem_req, dmem_req, dmem_we, pc_we, ir_we, reg_we;
  logic [1:0] npc_sel, reg_dst, wd_sel;
  logic [2:0] alu_op, state;
  logic       alu_src_b, ext_op, instr_done, illegal, bus_err;

  obs_t  got;
  step_t q[$];
  int    vectors = 0;
  int    miscompares = 0;
  string tag;

  always #5 clk = ~clk;

  mips_mc_ctrl #(.WAIT_LIMIT(15), .CNT_W(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .opcode     (opcode),
    .funct      (funct),
    .alu_zero   (alu_zero),
    .imem_ready (imem_ready),
    .dmem_ready (dmem_ready),
    .imem_req   (imem_req),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .pc_we      (pc_we),
    .ir_we      (ir_we),
    .reg_we     (reg_we),
    .npc_sel    (npc_sel),
    .alu_op     (alu_op),
    .alu_src_b  (alu_src_b),
    .ext_op     (ext_op),
    .reg_dst    (reg_dst),
    .wd_sel     (wd_sel),
    .instr_done (instr_done),
    .illegal    (illegal),
    .bus_err    (bus_err),
    .state      (state)
  );

  assign got = {state, imem_req, dmem_req, dmem_we, pc_we, ir_we, reg_we, npc_sel,
                alu_op, alu_src_b, ext_op, reg_dst, wd_sel, instr_done, illegal, bus_err};

  function automatic obs_t idle(input logic [2:0] st);
    obs_t o;
    o = '0;
    o.st = st;
    return o;
  endfunction

  task automatic push(input obs_t o, input logic ir, input logic dr, input logic z);
    step_t s;
    s.o = o; s.ir = ir; s.dr = dr; s.z = z;
    q.push_back(s);
  endtask

  task automatic check(input obs_t exp, input string t);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", t, got, exp);
    end
  endtask

  // Expected per-cycle outputs of one instruction, straight from the ISA table.
  task automatic build(input logic [5:0] op, input logic [5:0] fn, input logic z,
                       input int idly, input int ddly);
    obs_t o, m;
    logic addu, subu, jr, ori, lui, lw, sw, beq, j, jal;
    addu = (op == 6'b000000) && (fn == 6'b100001);
    subu = (op == 6'b000000) && (fn == 6'b100011);
    jr   = (op == 6'b000000) && (fn == 6'b001000);
    ori  = (op == 6'b001101);
    lui  = (op == 6'b001111);
    lw   = (op == 6'b100011);
    sw   = (op == 6'b101011);
    beq  = (op == 6'b000100);
    j    = (op == 6'b000010);
    jal  = (op == 6'b000011);
    for (int i = 0; i < idly; i++) begin
      o = idle(3'd0); o.ireq = 1'b1;
      push(o, 1'b0, 1'b0, z);
    end
    o = idle(3'd0); o.ireq = 1'b1; o.irwe = 1'b1; o.pcwe = 1'b1;
    push(o, 1'b1, 1'b0, z);
    if (!(addu || subu || jr || ori || lui || lw || sw || beq || j || jal)) begin
      o = idle(3'd1); o.done = 1'b1; o.ill = 1'b1;
      push(o, 1'b0, 1'b0, z);
      return;
    end
    push(idle(3'd1), 1'b0, 1'b0, z);
    o = idle(3'd2);
    if (subu || beq) o.aop = 3'b001;
    if (ori) begin o.aop = 3'b010; o.asrc = 1'b1; end
    if (lui) begin o.aop = 3'b011; o.asrc = 1'b1; end
    if (lw || sw) begin o.asrc = 1'b1; o.ext = 1'b1; end
    if (beq) begin o.pcwe = z; o.npc = 2'b01; o.done = 1'b1; end
    if (j || jal) begin o.pcwe = 1'b1; o.npc = 2'b10; o.done = j; end
    if (jr) begin o.pcwe = 1'b1; o.npc = 2'b11; o.done = 1'b1; end
    push(o, 1'b0, 1'b0, z);
    if (beq || j || jr) return;
    if (lw || sw) begin
      m = o; m.st = 3'd3; m.dreq = 1'b1; m.dwe = sw;
      for (int i = 0; i < ddly; i++) push(m, 1'b0, 1'b0, z);
      m.done = sw;
      push(m, 1'b0, 1'b1, z);
      if (sw) return;
    end
    m = o; m.st = 3'd4; m.pcwe = 1'b0; m.npc = 2'b00; m.regwe = 1'b1; m.done = 1'b1;
    if (addu || subu) m.rdst = 2'b01;
    if (lw) m.wsel = 2'b01;
    if (jal) begin m.rdst = 2'b10; m.wsel = 2'b10; end
    push(m, 1'b0, 1'b0, z);
  endtask

  // Pop up to n expected steps; each drives its inputs and is compared mid-cycle.
  task automatic run(input int n);
    step_t s;
    for (int k = 0; k < n && q.size() > 0; k++) begin
      s = q.pop_front();
      imem_ready = s.ir;
      dmem_ready = s.dr;
      alu_zero   = s.z;
      @(negedge clk);
      check(s.o, $sformatf("%s cyc%0d", tag, k));
      @(posedge clk);
      #1;
    end
  endtask

  task automatic instr(input string t, input logic [5:0] op, input logic [5:0] fn,
                       input logic z, input int idly, input int ddly);
    tag = t; opcode = op; funct = fn;
    build(op, fn, z, idly, ddly);
    run(q.size());
  endtask

  initial begin
    obs_t o;
    #2;
    tag = "reset";
    check(idle(3'd0), tag);
    @(posedge clk); #1;
    check(idle(3'd0), "reset_hold");
    reset = 1'b1;

    instr("addu",      6'b000000, 6'b100001, 1'b0, 0, 0);
    instr("subu_iw2",  6'b000000, 6'b100011, 1'b0, 2, 0);
    instr("lw_dw3",    6'b100011, 6'b000000, 1'b0, 0, 3);
    instr("beq_z0",    6'b000100, 6'b000000, 1'b0, 0, 0);
    instr("beq_z1",    6'b000100, 6'b000000, 1'b1, 0, 0);
    instr("jal",       6'b000011, 6'b000000, 1'b0, 0, 0);
    instr("illegal",   6'b111111, 6'b000000, 1'b0, 0, 0);
    instr("ori",       6'b001101, 6'b000000, 1'b0, 0, 0);
    instr("lui",       6'b001111, 6'b000000, 1'b0, 0, 0);
    instr("j",         6'b000010, 6'b000000, 1'b0, 1, 0);
    instr("jr",        6'b000000, 6'b001000, 1'b0, 0, 0);
    instr("sw",        6'b101011, 6'b000000, 1'b0, 0, 1);
    instr("bad_funct", 6'b000000, 6'b100000, 1'b0, 0, 0);

    // Abort a store while it waits in MEM.
    tag = "sw_abort"; opcode = 6'b101011; funct = '0;
    build(6'b101011, 6'b000000, 1'b0, 0, 10);
    run(5);
    q.delete();
    #2 reset = 1'b0;
    #1 check(idle(3'd0), "sw_abort_async");
    @(posedge clk); #1;
    check(idle(3'd0), "sw_abort_held");
    reset = 1'b1;
    instr("addu_after_abort", 6'b000000, 6'b100001, 1'b0, 0, 0);

    // Instruction memory never answers: 16 waiting cycles then trap.
    tag = "imem_timeout";
    for (int i = 0; i < 16; i++) begin
      o = idle(3'd0); o.ireq = 1'b1;
      push(o, 1'b0, 1'b0, 1'b0);
    end
    o = idle(3'd5); o.berr = 1'b1;
    for (int i = 0; i < 4; i++) push(o, 1'b0, 1'b0, 1'b0);
    run(q.size());
    #2 reset = 1'b0;
    #1 check(idle(3'd0), "err_reset_async");
    @(posedge clk); #1;
    check(idle(3'd0), "err_reset_held");
    reset = 1'b1;
    instr("ori_after_err", 6'b001101, 6'b000000, 1'b0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed state %0d", state);
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
